// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: FSM states, access encodings
// and the alignment/legality check used on every request.
package dmem_responder_pkg;

  localparam int unsigned DMEM_DEPTH = 256;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_BUSY,
    DM_RESP
  } dmem_state_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LW  = 3'd2,
    LD_LBU = 3'd4,
    LD_LHU = 3'd5
  } load_conf_e;

  typedef enum logic [2:0] {
    ST_SB = 3'd0,
    ST_SH = 3'd1,
    ST_SW = 3'd2
  } store_conf_e;

  // Misaligned or unknown access encoding; the range check lives in the top.
  function automatic logic access_fault(input logic       we,
                                        input logic [1:0] lane,
                                        input logic [2:0] ld_conf,
                                        input logic [2:0] st_conf);
    logic f;
    if (we) begin
      case (st_conf)
        ST_SB:   f = 1'b0;
        ST_SH:   f = lane[0];
        ST_SW:   f = |lane;
        default: f = 1'b1;
      endcase
    end else begin
      case (ld_conf)
        LD_LB, LD_LBU: f = 1'b0;
        LD_LH, LD_LHU: f = lane[0];
        LD_LW:         f = |lane;
        default:       f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/dmem_responder_load_extend.sv
// Load lane selection with sign/zero extension of the addressed byte/halfword.
module load_extend
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  ld_conf,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{lane, 3'b000} +: 8];
    h    = lane[1] ? word[31:16] : word[15:0];
    data = '0;
    case (ld_conf)
      LD_LB:   data = {{24{b[7]}}, b};
      LD_LBU:  data = {24'h000000, b};
      LD_LH:   data = {{16{h[15]}}, h};
      LD_LHU:  data = {16'h0000, h};
      LD_LW:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts a load/store, waits
// MEM_DELAY cycles, then pulses one registered response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = DMEM_DEPTH,
  parameter int unsigned MEM_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ld_conf,
  input  logic [2:0]  req_st_conf,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dmem_state_e state;
  logic [3:0]  cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_ld_conf;
  logic [2:0]  r_st_conf;

  logic [31:0] mem [DEPTH];

  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [2:0]    acc_ld_conf;
  logic [2:0]    acc_st_conf;
  logic          do_access;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [31:0]   ld_data;

  assign req_ready = (state == DM_IDLE);

  // With MEM_DELAY = 0 the array is accessed on the accepting edge, before the
  // request registers are loaded, so the live request fields are used instead.
  always_comb begin
    if (state == DM_IDLE) begin
      acc_we      = req_we;
      acc_addr    = req_addr;
      acc_wdata   = req_wdata;
      acc_ld_conf = req_ld_conf;
      acc_st_conf = req_st_conf;
    end else begin
      acc_we      = r_we;
      acc_addr    = r_addr;
      acc_wdata   = r_wdata;
      acc_ld_conf = r_ld_conf;
      acc_st_conf = r_st_conf;
    end
  end

  always_comb begin
    do_access = ((state == DM_IDLE) && req_valid && (MEM_DELAY == 0)) ||
                ((state == DM_BUSY) && (cnt == '0));
    acc_err   = access_fault(acc_we, acc_addr[1:0], acc_ld_conf, acc_st_conf) ||
                ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    acc_idx   = acc_addr[AW+1:2];
    rd_word   = mem[acc_idx];
  end

  always_comb begin
    wr_word = rd_word;
    case (acc_st_conf)
      ST_SB:   wr_word[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
      ST_SH:   wr_word[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
      ST_SW:   wr_word = acc_wdata;
      default: wr_word = rd_word;
    endcase
  end

  load_extend u_load_extend (
    .word    (rd_word),
    .lane    (acc_addr[1:0]),
    .ld_conf (acc_ld_conf),
    .data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err) begin
      mem[acc_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DM_IDLE;
      cnt        <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ld_conf  <= '0;
      r_st_conf  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        DM_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_ld_conf <= req_ld_conf;
            r_st_conf <= req_st_conf;
            if (MEM_DELAY == 0) begin
              state <= DM_RESP;
            end else begin
              state <= DM_BUSY;
              cnt   <= 4'(MEM_DELAY - 1);
            end
          end
        end
        DM_BUSY: begin
          if (cnt == '0) begin
            state <= DM_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DM_RESP: state <= DM_IDLE;
        default: state <= DM_IDLE;
      endcase
      if (do_access) begin
        resp_valid <= 1'b1;
        resp_err   <= acc_err;
        resp_rdata <= (acc_we || acc_err) ? '0 : ld_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: one responder with MEM_DELAY=1 and one with MEM_DELAY=0.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v1 = 1'b0, we1 = 1'b0, rdy1, rv1, er1;
  logic [31:0] a1 = '0, wd1 = '0, rd1;
  logic [2:0]  ld1 = '0, st1 = '0;
  logic        v0 = 1'b0, we0 = 1'b0, rdy0, rv0, er0;
  logic [31:0] a0 = '0, wd0 = '0, rd0;
  logic [2:0]  ld0 = '0, st0 = '0;

  dmem_responder #(.DEPTH(256), .MEM_DELAY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_addr(a1), .req_wdata(wd1), .req_ld_conf(ld1), .req_st_conf(st1),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1)
  );

  dmem_responder #(.DEPTH(256), .MEM_DELAY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_addr(a0), .req_wdata(wd0), .req_ld_conf(ld0), .req_st_conf(st0),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
  } exp_t;

  exp_t        q1[$];
  exp_t        q0[$];
  exp_t        e1, e0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned resp0_cnt = 0;
  logic        prev_rv1 = 1'b0, prev_rv0 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Latency counts edges from the accepting edge (inclusive) to the edge raising resp_valid.
  always @(negedge clk) begin
    if (rv1) begin
      chk("d1_resp_expected", 32'(q1.size() != 0), 1);
      chk("d1_pulse", 32'(prev_rv1), 0);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("d1_rdata", rd1, e1.rdata);
        chk("d1_err", 32'(er1), 32'(e1.err));
        chk("d1_latency", cyc - e1.acc + 1, 2);
      end
    end else if (prev_rv1) begin
      chk("d1_rdata_idle", rd1, 0);
      chk("d1_err_idle", 32'(er1), 0);
    end
    prev_rv1 <= rv1;
  end

  always @(negedge clk) begin
    if (rv0) begin
      resp0_cnt <= resp0_cnt + 1;
      chk("d0_resp_expected", 32'(q0.size() != 0), 1);
      chk("d0_pulse", 32'(prev_rv0), 0);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("d0_rdata", rd0, e0.rdata);
        chk("d0_err", 32'(er0), 32'(e0.err));
        chk("d0_latency", cyc - e0.acc + 1, 1);
      end
    end
    prev_rv0 <= rv0;
  end

  task automatic drain1();
    int unsigned n;
    n = 0;
    while (q1.size() != 0 && n < 32) begin
      @(negedge clk);
      n++;
    end
    chk("d1_drain", q1.size(), 0);
  endtask

  task automatic issue1(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] ld, input logic [2:0] st,
                        input logic [31:0] er, input logic ee);
    int unsigned n;
    @(negedge clk);
    v1 = 1'b1; we1 = we; a1 = a; wd1 = wd; ld1 = ld; st1 = st;
    n = 0;
    while (!rdy1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("d1_accept", 32'(rdy1), 1);
    if (rdy1) q1.push_back('{er, ee, cyc + 1});
    @(negedge clk);
    v1 = 1'b0;
    drain1();
  endtask

  task automatic load1(input logic [31:0] a, input logic [2:0] c,
                       input logic [31:0] er, input logic ee);
    issue1(1'b0, a, 32'h0, c, ST_SW, er, ee);
  endtask

  task automatic store1(input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] c, input logic ee);
    issue1(1'b1, a, wd, LD_LW, c, 32'h0, ee);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned last;
    logic [31:0] er;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready1", 32'(rdy1), 1);
    chk("rst_valid1", 32'(rv1), 0);
    chk("rst_rdata1", rd1, 0);
    chk("rst_err1", 32'(er1), 0);
    chk("rst_ready0", 32'(rdy0), 1);

    store1(32'h10, 32'h80000001, ST_SW, 1'b0);
    load1 (32'h10, LD_LW,  32'h80000001, 1'b0);
    load1 (32'h13, LD_LB,  32'hFFFFFF80, 1'b0);
    load1 (32'h13, LD_LBU, 32'h00000080, 1'b0);
    load1 (32'h10, LD_LH,  32'h00000001, 1'b0);
    load1 (32'h12, LD_LHU, 32'h00008000, 1'b0);
    load1 (32'h12, LD_LH,  32'hFFFF8000, 1'b0);
    store1(32'h11, 32'h123456AB, ST_SB, 1'b0);
    load1 (32'h10, LD_LW,  32'h8000AB01, 1'b0);
    load1 (32'h10, LD_LB,  32'h00000001, 1'b0);
    load1 (32'h12, LD_LW,  32'h0, 1'b1);
    store1(32'h11, 32'hFFFFFFFF, ST_SH, 1'b1);
    load1 (32'h400, LD_LW, 32'h0, 1'b1);
    load1 (32'h10, 3'd3,   32'h0, 1'b1);
    store1(32'h10, 32'hFFFFFFFF, 3'd5, 1'b1);
    store1(32'h400, 32'hFFFFFFFF, ST_SW, 1'b1);
    load1 (32'h10, LD_LW,  32'h8000AB01, 1'b0);
    store1(32'h3FC, 32'h55AA1234, ST_SW, 1'b0);
    store1(32'h3FE, 32'hFFFF9999, ST_SH, 1'b0);
    load1 (32'h3FC, LD_LW, 32'h99991234, 1'b0);

    store1(32'h20, 32'h11223344, ST_SW, 1'b0);
    load1 (32'h20, LD_LW,  32'h11223344, 1'b0);
    @(negedge clk);
    v1 = 1'b1; we1 = 1'b1; a1 = 32'h20; wd1 = 32'hDEADBEEF; st1 = ST_SW;
    chk("abort_ready_pre", 32'(rdy1), 1);
    @(negedge clk);
    v1 = 1'b0;
    chk("abort_busy", 32'(rdy1), 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready_post", 32'(rdy1), 1);
    repeat (3) @(negedge clk);
    load1 (32'h20, LD_LW,  32'h11223344, 1'b0);

    last = 0;
    @(negedge clk);
    v0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin we0 = 1'b1; a0 = 32'h40; wd0 = 32'hCAFEF00D; st0 = ST_SW; er = 32'h0; end
        1: begin we0 = 1'b0; a0 = 32'h40; ld0 = LD_LW;  er = 32'hCAFEF00D; end
        2: begin we0 = 1'b0; a0 = 32'h42; ld0 = LD_LHU; er = 32'h0000CAFE; end
        default: begin we0 = 1'b0; a0 = 32'h41; ld0 = LD_LB; er = 32'hFFFFFFF0; end
      endcase
      n = 0;
      while (!rdy0 && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk("d0_wait", n, (i == 0) ? 0 : 1);
      q0.push_back('{er, 1'b0, cyc + 1});
      if (i > 0) chk("d0_interval", cyc + 1 - last, 2);
      last = cyc + 1;
      @(negedge clk);
      chk("d0_ready_in_resp", 32'(rdy0), 0);
      chk("d0_valid_in_resp", 32'(rv0), 1);
    end
    v0 = 1'b0;
    n = 0;
    while (q0.size() != 0 && n < 16) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("d0_drain", q0.size(), 0);
    chk("d0_resp_count", resp0_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
